// File: rtl/cube_pkg.sv
// Shared constants, geometry and FSM state type for the LED cube frame transmitter.
package cube_pkg;
  localparam logic [7:0] CUBE_CMD_ADDR_WR = 8'hcc;
  localparam logic [7:0] CUBE_CMD_DATA_WR = 8'hda;
  localparam int LAYER_NUM   = 8;
  localparam int PIXEL_NUM   = 64;
  localparam int COLOR_BYTES = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD_A,
    ST_AFETCH,
    ST_AWAIT,
    ST_ASEND,
    ST_CMD_D,
    ST_DFETCH,
    ST_DWAIT,
    ST_DSEND,
    ST_DONE
  } tx_state_t;
endpackage

// File: rtl/pixel_unpack.sv
// Holds one 24-bit colour word and presents it one byte at a time, MSB byte first.
module pixel_unpack
  import cube_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear,
  input  logic        load,
  input  logic [23:0] load_data,
  input  logic        advance,
  output logic [7:0]  cur_byte,
  output logic        last_byte
);
  logic [23:0] pix_q;
  logic [1:0]  idx_q;

  // clear outranks load so an abort in the wait state leaves nothing behind
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pix_q <= '0;
      idx_q <= '0;
    end else if (clear) begin
      pix_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      pix_q <= load_data;
      idx_q <= 2'd0;
    end else if (advance && !last_byte) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = pix_q[23:16];
      2'd1:    cur_byte = pix_q[15:8];
      default: cur_byte = pix_q[7:0];
    endcase
  end

  assign last_byte = (idx_q == 2'(COLOR_BYTES - 1));
endmodule

// File: rtl/cube_frame_tx.sv
// Streams one cube frame (optional address table, then colour data layer 7..0) as a byte stream.
// Byte handshake: a byte moves when byte_valid_out & byte_ready_in are both high on a clock edge; while valid is high and ready low, data and dc hold still.
module cube_frame_tx
  import cube_pkg::*;
#(
  parameter logic [7:0] CMD_ADDR_WR = CUBE_CMD_ADDR_WR,
  parameter logic [7:0] CMD_DATA_WR = CUBE_CMD_DATA_WR,
  parameter bit         SEND_ADDR   = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  input  logic        abort_in,
  output logic        rd_en_out,
  output logic        rd_sel_out,
  output logic [8:0]  rd_addr_out,
  input  logic [23:0] rd_data_in,
  output logic        byte_valid_out,
  input  logic        byte_ready_in,
  output logic [7:0]  byte_data_out,
  output logic        dc_out,
  output logic        busy_out,
  output logic        frame_done_out,
  output tx_state_t   state_dbg_out
);
  localparam logic [5:0] PIX_LAST  = 6'(PIXEL_NUM - 1);
  localparam logic [2:0] LAYER_TOP = 3'(LAYER_NUM - 1);

  tx_state_t  state_q;
  logic [5:0] pixel_q;
  logic [2:0] layer_q;
  logic [7:0] byte_q;
  logic       color_q;
  logic       accept;
  logic       do_abort;
  logic [7:0] unpack_byte;
  logic       unpack_last;

  assign accept        = byte_valid_out && byte_ready_in;
  assign do_abort      = abort_in && (state_q != ST_IDLE);
  assign byte_data_out = color_q ? unpack_byte : byte_q;
  assign state_dbg_out = state_q;

  pixel_unpack u_unpack (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear     (do_abort),
    .load      (state_q == ST_DWAIT),
    .load_data (rd_data_in),
    .advance   ((state_q == ST_DSEND) && accept),
    .cur_byte  (unpack_byte),
    .last_byte (unpack_last)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      pixel_q        <= '0;
      layer_q        <= '0;
      byte_q         <= '0;
      color_q        <= 1'b0;
      rd_en_out      <= 1'b0;
      rd_sel_out     <= 1'b0;
      rd_addr_out    <= '0;
      byte_valid_out <= 1'b0;
      dc_out         <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else if (do_abort) begin
      state_q        <= ST_IDLE;
      pixel_q        <= '0;
      layer_q        <= '0;
      byte_q         <= '0;
      color_q        <= 1'b0;
      rd_en_out      <= 1'b0;
      rd_sel_out     <= 1'b0;
      rd_addr_out    <= '0;
      byte_valid_out <= 1'b0;
      dc_out         <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      rd_en_out      <= 1'b0;
      frame_done_out <= 1'b0;
      case (state_q)
        ST_IDLE: if (frame_start_in) begin
          busy_out       <= 1'b1;
          byte_valid_out <= 1'b1;
          dc_out         <= 1'b0;
          pixel_q        <= '0;
          layer_q        <= '0;
          byte_q         <= SEND_ADDR ? CMD_ADDR_WR : CMD_DATA_WR;
          state_q        <= SEND_ADDR ? ST_CMD_A : ST_CMD_D;
        end
        ST_CMD_A: if (accept) begin
          byte_valid_out <= 1'b0;
          rd_en_out      <= 1'b1;
          rd_sel_out     <= 1'b0;
          rd_addr_out    <= '0;
          pixel_q        <= '0;
          state_q        <= ST_AFETCH;
        end
        ST_AFETCH: state_q <= ST_AWAIT;
        ST_AWAIT: begin
          byte_q         <= rd_data_in[7:0];
          dc_out         <= 1'b1;
          byte_valid_out <= 1'b1;
          state_q        <= ST_ASEND;
        end
        ST_ASEND: if (accept) begin
          if (pixel_q == PIX_LAST) begin
            // data command follows the last address byte without a bubble
            byte_q  <= CMD_DATA_WR;
            dc_out  <= 1'b0;
            state_q <= ST_CMD_D;
          end else begin
            byte_valid_out <= 1'b0;
            pixel_q        <= pixel_q + 6'd1;
            rd_en_out      <= 1'b1;
            rd_addr_out    <= {3'd0, pixel_q + 6'd1};
            state_q        <= ST_AFETCH;
          end
        end
        ST_CMD_D: if (accept) begin
          byte_valid_out <= 1'b0;
          layer_q        <= LAYER_TOP;
          pixel_q        <= '0;
          rd_en_out      <= 1'b1;
          rd_sel_out     <= 1'b1;
          rd_addr_out    <= {LAYER_TOP, 6'd0};
          state_q        <= ST_DFETCH;
        end
        ST_DFETCH: state_q <= ST_DWAIT;
        ST_DWAIT: begin
          byte_valid_out <= 1'b1;
          dc_out         <= 1'b1;
          color_q        <= 1'b1;
          state_q        <= ST_DSEND;
        end
        ST_DSEND: if (accept && unpack_last) begin
          byte_valid_out <= 1'b0;
          color_q        <= 1'b0;
          if (pixel_q == PIX_LAST && layer_q == 3'd0) begin
            frame_done_out <= 1'b1;
            state_q        <= ST_DONE;
          end else if (pixel_q == PIX_LAST) begin
            layer_q     <= layer_q - 3'd1;
            pixel_q     <= '0;
            rd_en_out   <= 1'b1;
            rd_addr_out <= {layer_q - 3'd1, 6'd0};
            state_q     <= ST_DFETCH;
          end else begin
            pixel_q     <= pixel_q + 6'd1;
            rd_en_out   <= 1'b1;
            rd_addr_out <= {layer_q, pixel_q + 6'd1};
            state_q     <= ST_DFETCH;
          end
        end
        ST_DONE: begin
          busy_out   <= 1'b0;
          rd_sel_out <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cube_frame_tx.sv
// Bench for cube_frame_tx: one instance with the address phase, one without, both fed from a frame RAM model.
module tb_cube_frame_tx;
  import cube_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  logic        start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
  logic        rd_en_a, rd_sel_a, valid_a, dc_a, busy_a, done_a;
  logic [8:0]  rd_addr_a;
  logic [23:0] rd_data_a;
  logic [7:0]  data_a;
  tx_state_t   st_a;

  logic        start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
  logic        rd_en_b, rd_sel_b, valid_b, dc_b, busy_b, done_b;
  logic [8:0]  rd_addr_b;
  logic [23:0] rd_data_b;
  logic [7:0]  data_b;
  tx_state_t   st_b;

  logic [7:0]  addr_tbl [64];
  logic [23:0] col_mem  [512];
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];

  int tests_run = 0, tests_failed = 0;
  int done_cnt, stall_err, first_valid_c, last_acc_c, done_c, post_valid, post_busy, first_bad;

  always #5 clk_in = ~clk_in;

  cube_frame_tx #(.SEND_ADDR(1'b1)) u_dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(start_a), .abort_in(abort_a),
    .rd_en_out(rd_en_a), .rd_sel_out(rd_sel_a), .rd_addr_out(rd_addr_a), .rd_data_in(rd_data_a),
    .byte_valid_out(valid_a), .byte_ready_in(ready_a), .byte_data_out(data_a), .dc_out(dc_a),
    .busy_out(busy_a), .frame_done_out(done_a), .state_dbg_out(st_a)
  );

  cube_frame_tx #(.SEND_ADDR(1'b0)) u_dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(start_b), .abort_in(abort_b),
    .rd_en_out(rd_en_b), .rd_sel_out(rd_sel_b), .rd_addr_out(rd_addr_b), .rd_data_in(rd_data_b),
    .byte_valid_out(valid_b), .byte_ready_in(ready_b), .byte_data_out(data_b), .dc_out(dc_b),
    .busy_out(busy_b), .frame_done_out(done_b), .state_dbg_out(st_b)
  );

  // Read data is valid only the cycle after a strobe; junk otherwise, with junk above the address-table byte.
  always @(posedge clk_in) begin
    if (rd_en_a) rd_data_a <= rd_sel_a ? col_mem[rd_addr_a] : {16'($urandom()), addr_tbl[rd_addr_a[5:0]]};
    else         rd_data_a <= 24'($urandom());
    if (rd_en_b) rd_data_b <= rd_sel_b ? col_mem[rd_addr_b] : {16'($urandom()), addr_tbl[rd_addr_b[5:0]]};
    else         rd_data_b <= 24'($urandom());
  end

  task automatic fill_ram(input bit pattern);
    for (int i = 0; i < 64; i++) addr_tbl[i] = pattern ? 8'(i) : 8'($urandom());
    for (int k = 0; k < 512; k++)
      col_mem[k] = pattern ? {8'(k * 3), 8'(k * 3 + 1), 8'(k * 3 + 2)} : 24'($urandom());
  endtask

  // Reference stream: {dc, byte} in wire order
  task automatic build_exp(input bit send_addr);
    logic [23:0] c;
    exp_q.delete();
    if (send_addr) begin
      exp_q.push_back({1'b0, 8'hcc});
      for (int p = 0; p < 64; p++) exp_q.push_back({1'b1, addr_tbl[p]});
    end
    exp_q.push_back({1'b0, 8'hda});
    for (int l = 7; l >= 0; l--)
      for (int p = 0; p < 64; p++) begin
        c = col_mem[l * 64 + p];
        exp_q.push_back({1'b1, c[23:16]});
        exp_q.push_back({1'b1, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
      end
  endtask

  function automatic int count_mismatch();
    int n = 0;
    first_bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin
        n++;
        if (first_bad < 0) first_bad = i;
      end
    return n;
  endfunction

  // Drives ready/start/abort for instance a at posedge+1 and records accepted bytes at negedge.
  task automatic capture_a(input int low_pct, input int start_every, input int abort_at, input int max_cyc);
    bit stalled = 0;
    bit aborted = 0;
    logic [8:0] held = '0;
    int after = 0;
    int tail = -1;
    got_q.delete();
    done_cnt = 0; stall_err = 0; first_valid_c = -1; last_acc_c = -1; done_c = -1;
    post_valid = -1; post_busy = -1;
    for (int c = 0; c < max_cyc; c++) begin
      ready_a = ($urandom_range(99) >= low_pct);
      start_a = (tail < 0 && start_every > 0 && (c % start_every) == start_every - 1);
      abort_a = (!aborted && abort_at >= 0 && valid_a && got_q.size() == abort_at);
      @(negedge clk_in);
      if (stalled && (!valid_a || {dc_a, data_a} !== held)) stall_err++;
      if (valid_a && first_valid_c < 0) first_valid_c = c;
      if (valid_a && ready_a && !abort_a) begin
        got_q.push_back({dc_a, data_a});
        last_acc_c = c;
      end
      if (done_a) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
        if (tail < 0) tail = 0;
      end
      stalled = valid_a && !ready_a && !abort_a;
      held = {dc_a, data_a};
      if (aborted) begin
        after++;
        if (after == 1) begin
          post_valid = int'(valid_a);
          post_busy  = int'(busy_a);
        end
      end
      if (abort_a) aborted = 1;
      if (tail >= 0) tail++;
      @(posedge clk_in); #1;
      if (tail > 5 || after > 5) break;
    end
    ready_a = 1'b1; start_a = 1'b0; abort_a = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    tests_run++;
    if ({rd_en_a, rd_sel_a, rd_addr_a, valid_a, data_a, dc_a, busy_a, done_a, st_a} !== '0) begin
      tests_failed++;
      $display("FAIL reset_a: outputs %h required 0", {rd_en_a, rd_sel_a, rd_addr_a, valid_a, data_a, dc_a, busy_a, done_a, st_a});
    end
    tests_run++;
    if ({rd_en_b, rd_sel_b, rd_addr_b, valid_b, data_b, dc_b, busy_b, done_b, st_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_b: outputs %h required 0", {rd_en_b, rd_sel_b, rd_addr_b, valid_b, data_b, dc_b, busy_b, done_b, st_b});
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  task automatic test_addr_frame();
    int mm;
    fill_ram(1'b1);
    build_exp(1'b1);
    start_a = 1'b1;
    @(negedge clk_in);
    tests_run++;
    if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL start_cycle_valid: got %b required 0", valid_a); end
    @(posedge clk_in); #1;
    start_a = 1'b0;
    capture_a(0, 0, -1, 8000);
    mm = count_mismatch();
    tests_run++;
    if (first_valid_c !== 0) begin tests_failed++; $display("FAIL first_byte_latency: got %0d required 0", first_valid_c); end
    tests_run++;
    if (got_q.size() == 0 || got_q[0] !== {1'b0, 8'hcc}) begin
      tests_failed++; $display("FAIL first_byte_cmd_addr: got size %0d required first {dc,byte}=0cc", got_q.size());
    end
    tests_run++;
    if (got_q.size() !== 1602) begin tests_failed++; $display("FAIL addr_frame_len: got %0d required 1602", got_q.size()); end
    tests_run++;
    if (mm !== 0) begin tests_failed++; $display("FAIL addr_frame_bytes: %0d wrong, first at %0d, required 0 wrong", mm, first_bad); end
    tests_run++;
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL addr_frame_done_cnt: got %0d required 1", done_cnt); end
    tests_run++;
    if (done_c !== last_acc_c + 1) begin tests_failed++; $display("FAIL done_timing: done at %0d required %0d", done_c, last_acc_c + 1); end
    tests_run++;
    if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL busy_after_done: got %b required 0", busy_a); end
  endtask

  task automatic test_no_addr();
    int mm, bad_reads = 0, tail = -1;
    fill_ram(1'b1);
    build_exp(1'b0);
    got_q.delete();
    done_cnt = 0;
    start_b = 1'b1;
    @(posedge clk_in); #1;
    start_b = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk_in);
      if (rd_en_b && !rd_sel_b) bad_reads++;
      if (valid_b && ready_b) got_q.push_back({dc_b, data_b});
      if (done_b) begin done_cnt++; if (tail < 0) tail = 0; end
      if (tail >= 0) tail++;
      @(posedge clk_in); #1;
      if (tail > 3) break;
    end
    mm = count_mismatch();
    tests_run++;
    if (got_q.size() == 0 || got_q[0] !== {1'b0, 8'hda}) begin
      tests_failed++; $display("FAIL noaddr_first_byte: got size %0d required first {dc,byte}=0da", got_q.size());
    end
    tests_run++;
    if (got_q.size() !== 1537) begin tests_failed++; $display("FAIL noaddr_len: got %0d required 1537", got_q.size()); end
    tests_run++;
    if (mm !== 0) begin tests_failed++; $display("FAIL noaddr_bytes: %0d wrong, first at %0d, required 0 wrong", mm, first_bad); end
    tests_run++;
    if (bad_reads !== 0) begin tests_failed++; $display("FAIL noaddr_table_reads: got %0d required 0", bad_reads); end
    tests_run++;
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL noaddr_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int mm;
    fill_ram(1'b0);
    build_exp(1'b1);
    start_a = 1'b1;
    @(posedge clk_in); #1;
    start_a = 1'b0;
    capture_a(30, 0, -1, 12000);
    mm = count_mismatch();
    tests_run++;
    if (got_q.size() !== 1602) begin tests_failed++; $display("FAIL bp_len: got %0d required 1602", got_q.size()); end
    tests_run++;
    if (mm !== 0) begin tests_failed++; $display("FAIL bp_bytes: %0d wrong, first at %0d, required 0 wrong", mm, first_bad); end
    tests_run++;
    if (stall_err !== 0) begin tests_failed++; $display("FAIL bp_stall_stable: got %0d unstable cycles required 0", stall_err); end
    tests_run++;
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL bp_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_start_spam();
    int mm;
    fill_ram(1'b0);
    build_exp(1'b1);
    start_a = 1'b1;
    @(posedge clk_in); #1;
    start_a = 1'b0;
    capture_a(0, 10, -1, 8000);
    mm = count_mismatch();
    tests_run++;
    if (got_q.size() !== 1602) begin tests_failed++; $display("FAIL spam_len: got %0d required 1602", got_q.size()); end
    tests_run++;
    if (mm !== 0) begin tests_failed++; $display("FAIL spam_bytes: %0d wrong, first at %0d, required 0 wrong", mm, first_bad); end
    tests_run++;
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL spam_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_abort();
    int mm;
    fill_ram(1'b0);
    build_exp(1'b1);
    start_a = 1'b1;
    @(posedge clk_in); #1;
    start_a = 1'b0;
    capture_a(20, 0, 99, 8000);
    mm = count_mismatch();
    tests_run++;
    if (got_q.size() !== 99) begin tests_failed++; $display("FAIL abort_accepted: got %0d required 99", got_q.size()); end
    tests_run++;
    if (mm !== 0) begin tests_failed++; $display("FAIL abort_prefix: %0d wrong, first at %0d, required 0 wrong", mm, first_bad); end
    tests_run++;
    if (post_valid !== 0) begin tests_failed++; $display("FAIL abort_valid: got %0d required 0", post_valid); end
    tests_run++;
    if (post_busy !== 0) begin tests_failed++; $display("FAIL abort_busy: got %0d required 0", post_busy); end
    tests_run++;
    if (done_cnt !== 0) begin tests_failed++; $display("FAIL abort_done: got %0d required 0", done_cnt); end
    fill_ram(1'b0);
    build_exp(1'b1);
    start_a = 1'b1;
    @(posedge clk_in); #1;
    start_a = 1'b0;
    capture_a(0, 0, -1, 8000);
    mm = count_mismatch();
    tests_run++;
    if (got_q.size() !== 1602) begin tests_failed++; $display("FAIL post_abort_len: got %0d required 1602", got_q.size()); end
    tests_run++;
    if (mm !== 0) begin tests_failed++; $display("FAIL post_abort_bytes: %0d wrong, first at %0d, required 0 wrong", mm, first_bad); end
    tests_run++;
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL post_abort_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int mm, idle_bad = 0;
    fill_ram(1'b0);
    build_exp(1'b1);
    start_a = 1'b1;
    @(posedge clk_in); #1;
    start_a = 1'b0;
    capture_a(0, 0, -1, 400);
    rst_in = 1'b1;
    #1;
    tests_run++;
    if ({rd_en_a, rd_sel_a, rd_addr_a, valid_a, data_a, dc_a, busy_a, done_a} !== '0) begin
      tests_failed++; $display("FAIL mid_reset_async: outputs %h required 0", {rd_en_a, rd_sel_a, rd_addr_a, valid_a, data_a, dc_a, busy_a, done_a});
    end
    repeat (3) @(negedge clk_in);
    tests_run++;
    if ({rd_en_a, rd_sel_a, rd_addr_a, valid_a, data_a, dc_a, busy_a, done_a} !== '0) begin
      tests_failed++; $display("FAIL mid_reset_held: outputs %h required 0", {rd_en_a, rd_sel_a, rd_addr_a, valid_a, data_a, dc_a, busy_a, done_a});
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if (valid_a || busy_a || rd_en_a || done_a) idle_bad++;
    end
    tests_run++;
    if (idle_bad !== 0) begin tests_failed++; $display("FAIL idle_after_reset: got %0d active cycles required 0", idle_bad); end
    @(posedge clk_in); #1;
    start_a = 1'b1;
    @(posedge clk_in); #1;
    start_a = 1'b0;
    capture_a(0, 0, -1, 8000);
    mm = count_mismatch();
    tests_run++;
    if (got_q.size() !== 1602) begin tests_failed++; $display("FAIL post_reset_len: got %0d required 1602", got_q.size()); end
    tests_run++;
    if (mm !== 0) begin tests_failed++; $display("FAIL post_reset_bytes: %0d wrong, first at %0d, required 0 wrong", mm, first_bad); end
  endtask

  initial begin
    test_reset();
    test_addr_frame();
    test_no_addr();
    test_backpressure();
    test_start_spam();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
